// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// UART_ARB_ID_PREFIX_EN adds the ID-prefix frame states to the state enum.
package uart_pkg;

    localparam int         UART_DATA_W = 8;
    localparam logic [4:0] ID_PREFIX   = 5'b10100;

`ifdef UART_ARB_ID_PREFIX_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_END,
        S_ID_ISSUE,
        S_ID_WAIT_START,
        S_ID_WAIT_END
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_END
    } arb_state_e;
`endif

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [2:0]      grant,
    output logic            valid
);

    logic [NREQ-1:0] req_rot;
    logic [2:0]      offset;
    logic [3:0]      sum;

    always_comb begin
        // Rotate so bit 0 is the requester at ptr, then find the lowest set bit.
        req_rot = NREQ'({req, req} >> ptr);
        offset  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) offset = 3'(k);
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
        grant = sum[2:0];
        valid = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ requesters.
// Optional build macro UART_ARB_ID_PREFIX_EN sends an ID byte before each payload.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int DATA_W        = UART_DATA_W,
    parameter int START_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   arb_en,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic [2:0]             grant_id,
    input  logic                   Tx_BUSY,
    output logic                   Tx_EN,
    output logic                   Tx_WR,
    output logic [DATA_W-1:0]      Tx_DATA,
    output logic                   tx_timeout
);

    localparam int              CNT_W   = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [NREQ-1:0] ACK_ONE = NREQ'(1);

    arb_state_e        state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        grant_id_q, grant_id_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              tx_wr_q, tx_wr_d;
    logic              tx_en_q, tx_en_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_timeout_q, tx_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef UART_ARB_ID_PREFIX_EN
    logic [DATA_W-1:0] payload_q, payload_d;
`endif

    logic [2:0]        pick_id;
    logic              pick_vld;
    logic [2:0]        ptr_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  cnt_sat;
    logic              timeout_hit;
    logic [DATA_W-1:0] req_bytes [8];

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_id),
        .valid (pick_vld)
    );

    for (genvar k = 0; k < 8; k++) begin : g_bytes
        if (k < NREQ) begin : g_used
            assign req_bytes[k] = req_data[k*DATA_W +: DATA_W];
        end else begin : g_unused
            assign req_bytes[k] = '0;
        end
    end

    assign ptr_next    = (grant_id_q == 3'(NREQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign cnt_sat     = (&cnt_q) ? cnt_q : cnt_inc;
    // Fires on the edge the counter would reach START_TIMEOUT-1, i.e. START_TIMEOUT cycles after Tx_WR.
    assign timeout_hit = (cnt_inc == CNT_W'(START_TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_id_d   = grant_id_q;
        ack_d        = '0;
        tx_wr_d      = 1'b0;
        tx_en_d      = 1'b1;
        tx_data_d    = tx_data_q;
        tx_timeout_d = 1'b0;
        cnt_d        = cnt_q;
`ifdef UART_ARB_ID_PREFIX_EN
        payload_d    = payload_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (arb_en && pick_vld && !Tx_BUSY) begin
                    grant_id_d = pick_id;
                    tx_wr_d    = 1'b1;
`ifdef UART_ARB_ID_PREFIX_EN
                    payload_d  = req_bytes[pick_id];
                    tx_data_d  = DATA_W'({ID_PREFIX, pick_id});
                    state_d    = S_ID_ISSUE;
`else
                    ack_d      = ACK_ONE << pick_id;
                    tx_data_d  = req_bytes[pick_id];
                    state_d    = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (Tx_BUSY) begin
                    state_d = S_WAIT_END;
                end else if (timeout_hit) begin
                    tx_timeout_d = 1'b1;
                    ptr_d        = ptr_next;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            S_WAIT_END: begin
                if (!Tx_BUSY) begin
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end
            end
`ifdef UART_ARB_ID_PREFIX_EN
            S_ID_ISSUE: begin
                cnt_d   = '0;
                state_d = S_ID_WAIT_START;
            end
            S_ID_WAIT_START: begin
                if (Tx_BUSY) begin
                    state_d = S_ID_WAIT_END;
                end else if (timeout_hit) begin
                    tx_timeout_d = 1'b1;
                    ptr_d        = ptr_next;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            S_ID_WAIT_END: begin
                if (!Tx_BUSY) begin
                    tx_wr_d   = 1'b1;
                    ack_d     = ACK_ONE << grant_id_q;
                    tx_data_d = payload_q;
                    state_d   = S_ISSUE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            grant_id_q   <= '0;
            ack_q        <= '0;
            tx_wr_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_timeout_q <= 1'b0;
            cnt_q        <= '0;
`ifdef UART_ARB_ID_PREFIX_EN
            payload_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_id_q   <= grant_id_d;
            ack_q        <= ack_d;
            tx_wr_q      <= tx_wr_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            tx_timeout_q <= tx_timeout_d;
            cnt_q        <= cnt_d;
`ifdef UART_ARB_ID_PREFIX_EN
            payload_q    <= payload_d;
`endif
        end
    end

    assign ack        = ack_q;
    assign grant_id   = grant_id_q;
    assign Tx_EN      = tx_en_q;
    assign Tx_WR      = tx_wr_q;
    assign Tx_DATA    = tx_data_q;
    assign tx_timeout = tx_timeout_q;

endmodule
